serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 159 +++++++++++++++
 tb/tb_serial_adder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder. Two WIDTH-bit operands and a carry-in are
// accepted over a valid/ready handshake. They are then added DIGIT bits per
// clock, LSB first, through one registered carry. A single DIGIT-bit adder
// slice is reused WIDTH/DIGIT times.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, the block has an extra 'sub' input. With sub=1 it computes
//   a - b - cin, and cout then means borrow-out.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands a, b, cin (and sub) are valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       WIDTH-bit operands
//   cin        carry-in (borrow-in when subtracting)
//   sub        subtract select (only with SERIAL_ADDER_SUB_EN)
//   out_valid  sum/cout are valid (DONE)
//   out_ready  consumer accepts the result
//   sum        WIDTH-bit result
//   cout       carry-out (borrow-out when subtracting)
//   busy       high in RUN and DONE
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_q, sub_d;
`endif

    logic [DIGIT:0]         digit_add;
    logic [WIDTH+DIGIT-1:0] sum_cat;

    always_comb begin
        digit_add = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                  + (DIGIT+1)'(carry_q);
        // New digit enters at the MSB end; after N digits the LSB digit
        // has travelled all the way down to bit 0.
        sum_cat   = {digit_add[DIGIT-1:0], sum_q};

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d   = a;
                    cnt_d = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    // a - b - cin == a + ~b + ~cin
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    sub_d   = sub;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];
                carry_d = digit_add[DIGIT];
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
`ifdef SERIAL_ADDER_SUB_EN
                    cout_d = digit_add[DIGIT] ^ sub_q;
`else
                    cout_d = digit_add[DIGIT];
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder. Seven instances cover several WIDTH/DIGIT
// combinations:
//   0: 8/1    1: 8/4    2: 16/1    3: 16/2    4: 16/4    5: 16/8    6: 16/16
module tb_serial_adder;

    localparam int NDUT = 7;

    function automatic int cfg_w(int i);
        return (i < 2) ? 8 : 16;
    endfunction

    function automatic int cfg_d(int i);
        case (i)
            0: return 1;
            1: return 4;
            2: return 1;
            3: return 2;
            4: return 4;
            5: return 8;
            default: return 16;
        endcase
    endfunction

    logic clk;
    logic rst_n;
    logic [NDUT-1:0][15:0] a_s, b_s, sum_s;
    logic [NDUT-1:0]       in_valid_s, in_ready_s, cin_s, out_valid_s;
    logic [NDUT-1:0]       out_ready_s, cout_s, busy_s;
`ifdef SERIAL_ADDER_SUB_EN
    logic [NDUT-1:0]       sub_s;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned W = cfg_w(g);
        localparam int unsigned D = cfg_d(g);
        serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid_s[g]),
            .in_ready (in_ready_s[g]),
            .a        (a_s[g][W-1:0]),
            .b        (b_s[g][W-1:0]),
            .cin      (cin_s[g]),
`ifdef SERIAL_ADDER_SUB_EN
            .sub      (sub_s[g]),
`endif
            .out_valid(out_valid_s[g]),
            .out_ready(out_ready_s[g]),
            .sum      (sum_s[g][W-1:0]),
            .cout     (cout_s[g]),
            .busy     (busy_s[g])
        );
        if (W < 16) begin : g_pad
            assign sum_s[g][15:W] = '0;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands. Returns {cout, sum}.
    function automatic logic [16:0] model(int w, logic [15:0] aa, logic [15:0] bb,
                                          logic c, logic s);
        longint mask, ai, bi, r;
        logic [16:0] res;
        mask = (longint'(1) << w) - 1;
        ai   = longint'(aa) & mask;
        bi   = longint'(bb) & mask;
        res  = '0;
        if (s) begin
            r = ai - bi - longint'(c);
            res[15:0] = 16'(r & mask);
            res[16]   = (r < 0);
        end else begin
            r = ai + bi + longint'(c);
            res[15:0] = 16'(r & mask);
            res[16]   = r[w];
        end
        return res;
    endfunction

    // Called just after a negedge; counts rising edges until out_valid.
    task automatic wait_out(input int k, output int lat);
        lat = 0;
        while (!out_valid_s[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_seen", 32'(out_valid_s[k]), 1);
    endtask

    task automatic run_op(input int k, input logic [15:0] aa, input logic [15:0] bb,
                          input logic c, input logic s, input int hold);
        int lat;
        logic [16:0] m;
        m = model(cfg_w(k), aa, bb, c, s);
        chk("in_ready_idle", 32'(in_ready_s[k]), 1);
        a_s[k]   = aa;
        b_s[k]   = bb;
        cin_s[k] = c;
`ifdef SERIAL_ADDER_SUB_EN
        sub_s[k] = s;
`endif
        in_valid_s[k] = 1'b1;
        @(negedge clk);
        // Scramble inputs: only the accept-edge values may matter.
        in_valid_s[k] = 1'b0;
        a_s[k]   = 16'($urandom);
        b_s[k]   = 16'($urandom);
        cin_s[k] = ~c;
        wait_out(k, lat);
        chk("latency", 32'(lat), 32'(cfg_w(k) / cfg_d(k)));
        chk("sum_model", 32'(sum_s[k]), 32'(m[15:0]));
        chk("cout_model", 32'(cout_s[k]), 32'(m[16]));
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid_s[k]), 1);
            chk("hold_sum", 32'(sum_s[k]), 32'(m[15:0]));
        end
        out_ready_s[k] = 1'b1;
        @(negedge clk);
        out_ready_s[k] = 1'b0;
        chk("valid_drop", 32'(out_valid_s[k]), 0);
        chk("in_ready_back", 32'(in_ready_s[k]), 1);
    endtask

    typedef struct {
        int          k;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        s;
        logic [15:0] es;
        logic        ec;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        int seen;
        rst_n       = 1'b0;
        a_s         = '0;
        b_s         = '0;
        cin_s       = '0;
        in_valid_s  = '0;
        out_ready_s = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub_s       = '0;
`endif

        vecs.push_back('{0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{0, 16'h005A, 16'h00A5, 1'b1, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{0, 16'h0012, 16'h0034, 1'b0, 1'b0, 16'h0046, 1'b0});
        vecs.push_back('{1, 16'h009C, 16'h0077, 1'b0, 1'b0, 16'h0013, 1'b1});
        vecs.push_back('{2, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{3, 16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0});
        vecs.push_back('{4, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0});
        vecs.push_back('{5, 16'h00FF, 16'hFF01, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{6, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{0, 16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0});
        vecs.push_back('{0, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b1});
        vecs.push_back('{0, 16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b0});
        vecs.push_back('{3, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1});
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_s[0]), 0);
        chk("rst_out_valid", 32'(out_valid_s[0]), 0);
        chk("rst_busy", 32'(busy_s[0]), 0);
        chk("rst_sum", 32'(sum_s[0]), 0);
        chk("rst_cout", 32'(cout_s[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready_s[0]), 1);

        // Reset in the middle of RUN discards the operation
        a_s[0] = 16'h0033;
        b_s[0] = 16'h0000;
        cin_s[0] = 1'b0;
        in_valid_s[0] = 1'b1;
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(busy_s[0]), 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid_s[0]), 0);
        chk("mid_rst_busy", 32'(busy_s[0]), 0);
        chk("mid_rst_sum", 32'(sum_s[0]), 0);
        chk("mid_rst_cout", 32'(cout_s[0]), 0);
        chk("mid_rst_in_ready", 32'(in_ready_s[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_in_ready", 32'(in_ready_s[0]), 1);
        out_ready_s[0] = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_s[0]) seen++;
        end
        out_ready_s[0] = 1'b0;
        chk("mid_no_result", 32'(seen), 0);

        // Table vectors; sum/cout are checked after the handshake (retained)
        foreach (vecs[i]) begin
            run_op(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, 0);
            chk($sformatf("vec%0d_sum", i), 32'(sum_s[vecs[i].k]), 32'(vecs[i].es));
            chk($sformatf("vec%0d_cout", i), 32'(cout_s[vecs[i].k]), 32'(vecs[i].ec));
        end

        // Backpressure with ignored in_valid pulses in RUN and DONE
        a_s[0] = 16'h0012;
        b_s[0] = 16'h0034;
        cin_s[0] = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub_s[0] = 1'b0;
`endif
        in_valid_s[0] = 1'b1;
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        @(negedge clk);
        a_s[0] = 16'h00FF;
        b_s[0] = 16'h00FF;
        in_valid_s[0] = 1'b1;
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        wait_out(0, lat);
        chk("bp_latency", 32'(lat + 2), 8);
        in_valid_s[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid_s[0]), 1);
            chk("bp_sum", 32'(sum_s[0]), 32'h46);
            chk("bp_cout", 32'(cout_s[0]), 0);
            chk("bp_in_ready", 32'(in_ready_s[0]), 0);
        end
        out_ready_s[0] = 1'b1;
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        out_ready_s[0] = 1'b0;
        chk("bp_no_accept", 32'(busy_s[0]), 0);
        chk("bp_valid_drop", 32'(out_valid_s[0]), 0);
        out_ready_s[0] = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid_s[0]) seen++;
        end
        out_ready_s[0] = 1'b0;
        chk("bp_no_second", 32'(seen), 0);

        // Randomised operations on the 16-bit instances
        for (int i = 0; i < 1000; i++) begin
            int k;
            logic s;
            k = $urandom_range(2, 6);
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            run_op(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), s,
                   $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
